// File: rtl/ibuffer.sv
// Instruction buffer between fetch and decode: circular queue of fetched
// instructions, compacting sparse fetch groups on enqueue and presenting up
// to DECODE_WIDTH entries per cycle to decode in show-ahead fashion.

package config_pkg;

  // Core configuration subset used by the front end.
  typedef struct packed {
    int unsigned INSTR_PER_FETCH;
    int unsigned ILEN;
    int unsigned PLEN;
    int unsigned IFU_INF_DEPTH;
  } cfg_t;

  localparam cfg_t EmptyCfg = '{
    INSTR_PER_FETCH: 32'd4,
    ILEN:            32'd32,
    PLEN:            32'd32,
    IFU_INF_DEPTH:   32'd8
  };

endpackage

module ibuffer #(
  parameter config_pkg::cfg_t Cfg          = config_pkg::EmptyCfg,
  parameter int unsigned      DEPTH        = 16,
  parameter int unsigned      DECODE_WIDTH = 4,
  localparam int unsigned     IPF          = Cfg.INSTR_PER_FETCH,
  localparam int unsigned     ILEN         = Cfg.ILEN,
  localparam int unsigned     PLEN         = Cfg.PLEN,
  localparam int unsigned     FTQW         = (Cfg.IFU_INF_DEPTH >= 2) ? $clog2(Cfg.IFU_INF_DEPTH) : 1,
  localparam int unsigned     PW           = $clog2(DEPTH),
  localparam int unsigned     CW           = PW + 1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  // fetch side
  input  logic                                   fe_valid_i,
  output logic                                   fe_ready_o,
  input  logic [IPF-1:0][ILEN-1:0]               fe_data_i,
  input  logic [PLEN-1:0]                        fe_pc_i,
  input  logic [IPF-1:0]                         fe_slot_valid_i,
  input  logic [IPF-1:0][PLEN-1:0]               fe_pred_npc_i,
  input  logic [IPF-1:0][FTQW-1:0]               fe_ftq_id_i,
  input  logic [IPF-1:0][2:0]                    fe_fetch_epoch_i,
  // backend control
  input  logic                                   flush_i,
  // decode side
  output logic [DECODE_WIDTH-1:0]                de_valid_o,
  input  logic                                   de_ready_i,
  output logic [DECODE_WIDTH-1:0][ILEN-1:0]      de_instr_o,
  output logic [DECODE_WIDTH-1:0][PLEN-1:0]      de_pc_o,
  output logic [DECODE_WIDTH-1:0][PLEN-1:0]      de_pred_npc_o,
  output logic [DECODE_WIDTH-1:0][FTQW-1:0]      de_ftq_id_o,
  output logic [DECODE_WIDTH-1:0][2:0]           de_fetch_epoch_o,
  output logic [CW-1:0]                          count_o
);

  // Entry storage, one array per field
  logic [ILEN-1:0] mem_instr_q [DEPTH];
  logic [PLEN-1:0] mem_pc_q    [DEPTH];
  logic [PLEN-1:0] mem_npc_q   [DEPTH];
  logic [FTQW-1:0] mem_ftq_q   [DEPTH];
  logic [2:0]      mem_epoch_q [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic                           enq_fire;
  logic                           deq_fire;
  logic [CW-1:0]                  enq_n;
  logic [CW-1:0]                  deq_n;
  logic [IPF-1:0][PW-1:0]         wr_idx;
  logic [DECODE_WIDTH-1:0][PW-1:0] rd_idx;

  // Accept only when a full group is guaranteed to fit, using registered count
  assign fe_ready_o = !flush_i && ((CW'(DEPTH) - count_q) >= CW'(IPF));
  assign count_o    = count_q;

  // Valid lanes form a contiguous prefix bounded by occupancy
  always_comb begin
    de_valid_o = '0;
    for (int unsigned k = 0; k < DECODE_WIDTH; k++) begin
      de_valid_o[k] = !flush_i && (count_q > CW'(k));
    end
  end

  // Compaction: each valid slot lands at tail plus the number of valid slots below it
  always_comb begin
    enq_fire = fe_valid_i && fe_ready_o;
    enq_n    = '0;
    wr_idx   = '0;
    for (int unsigned i = 0; i < IPF; i++) begin
      wr_idx[i] = tail_q + PW'(enq_n);
      if (fe_slot_valid_i[i]) begin
        enq_n = enq_n + CW'(1);
      end
    end
    if (!enq_fire) begin
      enq_n = '0;
    end
  end

  // Dequeue takes every valid lane when decode is ready
  always_comb begin
    deq_fire = de_ready_i && de_valid_o[0];
    deq_n    = '0;
    for (int unsigned k = 0; k < DECODE_WIDTH; k++) begin
      if (deq_fire && de_valid_o[k]) begin
        deq_n = deq_n + CW'(1);
      end
    end
  end

  // Pointer and occupancy next state; flush clears everything
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PW'(deq_n);
      tail_d  = tail_q + PW'(enq_n);
      count_d = count_q + enq_n - deq_n;
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage write of the compacted fetch group
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned j = 0; j < DEPTH; j++) begin
        mem_instr_q[j] <= '0;
        mem_pc_q[j]    <= '0;
        mem_npc_q[j]   <= '0;
        mem_ftq_q[j]   <= '0;
        mem_epoch_q[j] <= '0;
      end
    end else if (enq_fire) begin
      for (int unsigned i = 0; i < IPF; i++) begin
        if (fe_slot_valid_i[i]) begin
          mem_instr_q[wr_idx[i]] <= fe_data_i[i];
          mem_pc_q[wr_idx[i]]    <= fe_pc_i + PLEN'(4 * i);
          mem_npc_q[wr_idx[i]]   <= fe_pred_npc_i[i];
          mem_ftq_q[wr_idx[i]]   <= fe_ftq_id_i[i];
          mem_epoch_q[wr_idx[i]] <= fe_fetch_epoch_i[i];
        end
      end
    end
  end

  // Show-ahead read: lane k reads entry head+k
  always_comb begin
    rd_idx           = '0;
    de_instr_o       = '0;
    de_pc_o          = '0;
    de_pred_npc_o    = '0;
    de_ftq_id_o      = '0;
    de_fetch_epoch_o = '0;
    for (int unsigned k = 0; k < DECODE_WIDTH; k++) begin
      rd_idx[k]           = head_q + PW'(k);
      de_instr_o[k]       = mem_instr_q[rd_idx[k]];
      de_pc_o[k]          = mem_pc_q[rd_idx[k]];
      de_pred_npc_o[k]    = mem_npc_q[rd_idx[k]];
      de_ftq_id_o[k]      = mem_ftq_q[rd_idx[k]];
      de_fetch_epoch_o[k] = mem_epoch_q[rd_idx[k]];
    end
  end

endmodule

// File: tb/tb_ibuffer.sv
// Directed self-checking bench for ibuffer (IPF=4, DECODE_WIDTH=4, DEPTH=16).

module tb_ibuffer;

  logic              clk;
  logic              rst_n;
  logic              fe_valid;
  logic              fe_ready;
  logic [3:0][31:0]  fe_data;
  logic [31:0]       fe_pc;
  logic [3:0]        fe_mask;
  logic [3:0][31:0]  fe_pred;
  logic [3:0][2:0]   fe_ftq;
  logic [3:0][2:0]   fe_epoch;
  logic              flush;
  logic [3:0]        de_valid;
  logic              de_ready;
  logic [3:0][31:0]  de_instr;
  logic [3:0][31:0]  de_pc;
  logic [3:0][31:0]  de_pred;
  logic [3:0][2:0]   de_ftq;
  logic [3:0][2:0]   de_epoch;
  logic [4:0]        count;

  int n_tests = 0;
  int n_fail  = 0;

  ibuffer dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .fe_valid_i       (fe_valid),
    .fe_ready_o       (fe_ready),
    .fe_data_i        (fe_data),
    .fe_pc_i          (fe_pc),
    .fe_slot_valid_i  (fe_mask),
    .fe_pred_npc_i    (fe_pred),
    .fe_ftq_id_i      (fe_ftq),
    .fe_fetch_epoch_i (fe_epoch),
    .flush_i          (flush),
    .de_valid_o       (de_valid),
    .de_ready_i       (de_ready),
    .de_instr_o       (de_instr),
    .de_pc_o          (de_pc),
    .de_pred_npc_o    (de_pred),
    .de_ftq_id_o      (de_ftq),
    .de_fetch_epoch_o (de_epoch),
    .count_o          (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if it mismatches
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ins(input int gid, input int i);
    return 32'hA000_0000 | (32'(gid) << 8) | 32'(i);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_group(input logic [31:0] pc, input logic [3:0] mask, input int gid);
    fe_valid = 1'b1;
    fe_pc    = pc;
    fe_mask  = mask;
    for (int i = 0; i < 4; i++) begin
      fe_data[i]  = ins(gid, i);
      fe_pred[i]  = pc + 32'(4 * i + 4);
      fe_ftq[i]   = 3'((gid + i) % 8);
      fe_epoch[i] = 3'(i) ^ 3'(gid);
    end
  endtask

  task automatic idle();
    fe_valid = 1'b0;
    fe_mask  = 4'b0;
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q_pc[$];
    logic [31:0] q_ins[$];
    int          mcount;
    int          g;
    int          cycles;
    int          nval;
    int          n_rx;
    logic [3:0]  mask;
    logic        exp_ready;

    rst_n    = 1'b0;
    flush    = 1'b0;
    de_ready = 1'b0;
    fe_data  = '0;
    fe_pred  = '0;
    fe_ftq   = '0;
    fe_epoch = '0;
    fe_pc    = '0;
    idle();

    // Reset state
    #12;
    check("rst_count", 64'(count), 64'd0);
    check("rst_valid", 64'(de_valid), 64'd0);
    check("rst_ready", 64'(fe_ready), 64'd1);
    check("rst_pc0", 64'(de_pc[0]), 64'd0);
    check("rst_instr3", 64'(de_instr[3]), 64'd0);
    rst_n = 1'b1;
    step();

    // Single full group, no bypass from empty
    set_group(32'h8000_0000, 4'hF, 1);
    #1;
    check("nobypass_valid", 64'(de_valid), 64'd0);
    step();
    idle();
    check("g1_valid", 64'(de_valid), 64'hF);
    check("g1_pc0", 64'(de_pc[0]), 64'h8000_0000);
    check("g1_pc1", 64'(de_pc[1]), 64'h8000_0004);
    check("g1_pc2", 64'(de_pc[2]), 64'h8000_0008);
    check("g1_pc3", 64'(de_pc[3]), 64'h8000_000C);
    check("g1_count", 64'(count), 64'd4);
    check("g1_instr3", 64'(de_instr[3]), 64'hA000_0103);
    check("g1_npc0", 64'(de_pred[0]), 64'h8000_0004);
    check("g1_ftq1", 64'(de_ftq[1]), 64'd2);
    check("g1_epoch2", 64'(de_epoch[2]), 64'd3);
    de_ready = 1'b1;
    step();
    de_ready = 1'b0;
    check("g1_drain", 64'(count), 64'd0);

    // Sparse mask compacts slots 1 and 3
    set_group(32'h100, 4'b1010, 2);
    step();
    idle();
    check("sp_valid", 64'(de_valid), 64'b0011);
    check("sp_pc0", 64'(de_pc[0]), 64'h104);
    check("sp_pc1", 64'(de_pc[1]), 64'h10C);
    check("sp_instr0", 64'(de_instr[0]), 64'hA000_0201);
    check("sp_instr1", 64'(de_instr[1]), 64'hA000_0203);
    check("sp_count", 64'(count), 64'd2);
    de_ready = 1'b1;
    step();
    de_ready = 1'b0;
    check("sp_drain", 64'(count), 64'd0);

    // Empty mask writes nothing
    set_group(32'h200, 4'b0000, 3);
    step();
    idle();
    check("zm_count", 64'(count), 64'd0);
    check("zm_valid", 64'(de_valid), 64'd0);

    // Fill to capacity
    for (int i = 0; i < 4; i++) begin
      set_group(32'h1000 + 32'(16 * i), 4'hF, 10 + i);
      step();
    end
    idle();
    check("full_count", 64'(count), 64'd16);
    check("full_ready", 64'(fe_ready), 64'd0);
    check("full_valid", 64'(de_valid), 64'hF);
    check("full_pc0", 64'(de_pc[0]), 64'h1000);
    de_ready = 1'b1;
    step();
    de_ready = 1'b0;
    check("deq1_count", 64'(count), 64'd12);
    check("deq1_ready", 64'(fe_ready), 64'd1);
    check("deq1_pc0", 64'(de_pc[0]), 64'h1010);
    check("deq1_instr3", 64'(de_instr[3]), 64'hA000_0B03);
    de_ready = 1'b1;
    repeat (3) step();
    de_ready = 1'b0;
    check("fill_drain", 64'(count), 64'd0);

    // Streaming across pointer wrap with continuous dequeue
    mcount = 0;
    g      = 0;
    cycles = 0;
    n_rx   = 0;
    while (!(g == 10 && mcount == 0) && cycles < 200) begin
      mask = (g % 3 == 0) ? 4'b0111 : 4'hF;
      if (g < 10) set_group(32'h2000 + 32'(16 * g), mask, 20 + g);
      else idle();
      de_ready = 1'b1;
      #1;
      exp_ready = ((16 - mcount) >= 4);
      check("st_ready", 64'(fe_ready), 64'(exp_ready));
      nval = (mcount < 4) ? mcount : 4;
      check("st_valid", 64'(de_valid), 64'((1 << nval) - 1));
      for (int k = 0; k < nval; k++) begin
        check("st_pc", 64'(de_pc[k]), 64'(q_pc[k]));
        check("st_instr", 64'(de_instr[k]), 64'(q_ins[k]));
      end
      for (int k = 0; k < nval; k++) begin
        void'(q_pc.pop_front());
        void'(q_ins.pop_front());
      end
      mcount -= nval;
      n_rx   += nval;
      if (g < 10 && exp_ready) begin
        for (int i = 0; i < 4; i++) begin
          if (mask[i]) begin
            q_pc.push_back(32'h2000 + 32'(16 * g) + 32'(4 * i));
            q_ins.push_back(ins(20 + g, i));
            mcount++;
          end
        end
        g++;
      end
      step();
      cycles++;
    end
    idle();
    de_ready = 1'b0;
    check("st_finished", 64'(g == 10 && mcount == 0), 64'd1);
    check("st_received", 64'(n_rx), 64'd36);
    check("st_count", 64'(count), 64'd0);

    // Flush with 9 entries while fetch and decode are both active
    set_group(32'h3000, 4'hF, 40);
    step();
    set_group(32'h3010, 4'hF, 41);
    step();
    set_group(32'h3020, 4'b0001, 42);
    step();
    idle();
    check("fl_pre_count", 64'(count), 64'd9);
    flush    = 1'b1;
    de_ready = 1'b1;
    set_group(32'h4000, 4'hF, 43);
    #1;
    check("fl_valid", 64'(de_valid), 64'd0);
    check("fl_ready", 64'(fe_ready), 64'd0);
    step();
    flush    = 1'b0;
    de_ready = 1'b0;
    idle();
    check("fl_count", 64'(count), 64'd0);
    check("fl_valid_after", 64'(de_valid), 64'd0);
    set_group(32'h5000, 4'hF, 44);
    step();
    idle();
    check("fl_refill_count", 64'(count), 64'd4);
    check("fl_refill_pc0", 64'(de_pc[0]), 64'h5000);
    check("fl_refill_instr1", 64'(de_instr[1]), 64'hA000_2C01);

    // Asynchronous reset between edges with 7 entries
    set_group(32'h6000, 4'b0111, 45);
    step();
    idle();
    check("ar_pre_count", 64'(count), 64'd7);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_count", 64'(count), 64'd0);
    check("ar_valid", 64'(de_valid), 64'd0);
    check("ar_pc0", 64'(de_pc[0]), 64'd0);
    check("ar_instr0", 64'(de_instr[0]), 64'd0);
    #1;
    rst_n = 1'b1;
    step();
    check("ar_post_count", 64'(count), 64'd0);
    check("ar_post_ready", 64'(fe_ready), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ibuffer.md
IBUFFER -- requirements
Module: ibuffer

Interface
REQ-001 Parameter Cfg, default config_pkg::EmptyCfg; supplies INSTR_PER_FETCH (IPF), ILEN, PLEN, IFU_INF_DEPTH.
REQ-002 Parameter DEPTH, default 16; instruction-entry capacity; power of two, DEPTH >= 2*IPF.
REQ-003 Parameter DECODE_WIDTH, default 4; decode lanes per cycle; 1 <= DECODE_WIDTH <= DEPTH.
REQ-004 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_ni  input  1  reset; asynchronous and active-low.
REQ-006 fe_valid_i  input  1  fetch group offered.
REQ-007 fe_ready_o  output  1  buffer accepts the group this cycle.
REQ-008 fe_data_i  input  IPF x ILEN  instruction words, slot 0 lowest PC.
REQ-009 fe_pc_i  input  PLEN  fetch-group PC of slot 0.
REQ-010 fe_slot_valid_i  input  IPF  per-slot valid mask; may be non-contiguous.
REQ-011 fe_pred_npc_i  input  IPF x PLEN  predicted next PC per slot.
REQ-012 fe_ftq_id_i  input  IPF x FTQW  FTQ id per slot; FTQW = clog2(IFU_INF_DEPTH) if IFU_INF_DEPTH >= 2, else 1.
REQ-013 fe_fetch_epoch_i  input  IPF x 3  fetch epoch per slot.
REQ-014 flush_i  input  1  backend flush; discards all contents.
REQ-015 de_valid_o  output  DECODE_WIDTH  per-lane valid to decode; always a contiguous prefix (lane 0 first).
REQ-016 de_ready_i  input  1  decode consumes every valid lane this cycle.
REQ-017 de_instr_o / de_pc_o / de_pred_npc_o / de_ftq_id_o / de_fetch_epoch_o  output  DECODE_WIDTH x (ILEN / PLEN / PLEN / FTQW / 3)  per-lane fields.
REQ-018 count_o  output  clog2(DEPTH)+1  current occupancy.

Function
REQ-019 Storage is a circular buffer of DEPTH entries {instr, pc, pred_npc, ftq_id, epoch} with head and tail pointers of clog2(DEPTH) bits, wrapping modulo DEPTH, plus a count register.
REQ-020 fe_ready_o = !flush_i && (DEPTH - count) >= IPF; uses the registered count only, ignoring same-cycle dequeue.
REQ-021 Enqueue fires when fe_valid_i && fe_ready_o; valid slots are compacted in ascending slot order and written at tail, tail+1, ...; tail and count advance by popcount(fe_slot_valid_i).
REQ-022 Entry pc of slot i = fe_pc_i + 4*i, truncated to PLEN bits; remaining fields copied from slot i.
REQ-023 A fire with fe_slot_valid_i = 0 writes nothing and leaves pointers unchanged.
REQ-024 Outputs are show-ahead (combinational from storage): lane k is driven from entry head+k mod DEPTH; de_valid_o[k] = (count > k) && !flush_i.
REQ-025 Dequeue fires when de_ready_i and de_valid_o[0] are both high; head advances by popcount(de_valid_o) and count decreases by the same amount.
REQ-026 On simultaneous enqueue and dequeue, count_next = count + enq_n - deq_n; count never exceeds DEPTH and never underflows.
REQ-027 flush_i takes priority: head, tail and count are zeroed at the next edge, the same-cycle enqueue and dequeue are suppressed, and fe_ready_o and de_valid_o are 0 in the flush cycle.
REQ-028 Enqueue latency: a group accepted at edge N is visible on de_valid_o in the cycle after edge N; there is no bypass from empty.
REQ-029 Data fields on invalid lanes are don't-care; benches compare valid lanes only.

Reset
REQ-030 While rst_ni = 0: head = tail = count = 0 and all storage = 0.
REQ-031 Reset values: de_valid_o = 0, count_o = 0, all de_* data outputs = 0, and fe_ready_o = 1 (given flush_i = 0).
REQ-032 Reset asserted mid-operation discards all contents immediately, without waiting for a clock edge.

Verification (IPF=4, DECODE_WIDTH=4, DEPTH=16)
REQ-033 Single group: pc=0x8000_0000, mask=4'b1111, de_ready_i=0 -> next cycle de_valid_o=4'b1111, lane pcs 0x80000000/04/08/0C, count_o=4.
REQ-034 Sparse mask 4'b1010, pc=0x100 -> lanes 0..1 valid with pc 0x104 and 0x10C; count_o=2.
REQ-035 Fill with de_ready_i=0: 4 full groups -> count_o=16, fe_ready_o=0; one dequeue -> count_o=12, fe_ready_o=1.
REQ-036 Wrap-around: stream 10 groups with continuous dequeue -> program order preserved across pointer wrap, no loss or duplication.
REQ-037 Flush with count_o=9 while fe_valid_i=1 and de_ready_i=1 -> that cycle de_valid_o=0 and fe_ready_o=0; next cycle count_o=0 and the offered group is not stored.
REQ-038 Asynchronous reset pulse between clock edges with count_o=7 -> count_o=0 and de_valid_o=0 immediately.
